// File: rtl/aes_pkg.sv
// ----------------------------------------------------------------------------
// aes_pkg
// Shared AES datapath definitions for the encrypt and decrypt pipelines.
//   state_t         : 128-bit AES state, column-major, byte k at [127-8k -: 8]
//   SHIFT_SRC       : per output byte, the input byte index that ShiftRows reads
//   INV_SHIFT_SRC   : same for InvShiftRows (exact inverse permutation)
//   shift_rows()    : forward ShiftRows
//   inv_shift_rows(): inverse ShiftRows
//   TAG_W_DEFAULT   : default round-tag width
// ----------------------------------------------------------------------------
package aes_pkg;

    localparam int STATE_W       = 128;
    localparam int NUM_BYTES     = 16;
    localparam int TAG_W_DEFAULT = 4;

    typedef logic [STATE_W-1:0] state_t;

    // Nibble i (counting from the MSB) is the source byte index of output byte i.
    // Forward: 0,5,10,15, 4,9,14,3, 8,13,2,7, 12,1,6,11
    localparam logic [63:0] SHIFT_SRC     = 64'h05AF_49E3_8D27_C16B;
    // Inverse: 0,13,10,7, 4,1,14,11, 8,5,2,15, 12,9,6,3
    localparam logic [63:0] INV_SHIFT_SRC = 64'h0DA7_41EB_852F_C963;

    // Byte gather driven by a constant index table, so both directions come
    // from one mapping source and reduce to pure wiring after synthesis.
    function automatic state_t permute_bytes(input state_t s, input logic [63:0] src_map);
        state_t     r;
        logic [3:0] src;
        r = '0;
        for (int i = 0; i < NUM_BYTES; i++) begin
            src = src_map[63-4*i -: 4];
            r[STATE_W-1-8*i -: 8] = s[STATE_W-1-8*int'(src) -: 8];
        end
        return r;
    endfunction

    function automatic state_t shift_rows(input state_t s);
        return permute_bytes(s, SHIFT_SRC);
    endfunction

    function automatic state_t inv_shift_rows(input state_t s);
        return permute_bytes(s, INV_SHIFT_SRC);
    endfunction

endpackage

// File: rtl/aes_fifo2.sv
// ----------------------------------------------------------------------------
// aes_fifo2
// Two-entry valid/ready FIFO. Storage, pointers and occupancy are registered;
// in_ready depends only on occupancy (and reset), never on out_ready.
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-high reset
//   in_valid  in   writer has an entry on in_data
//   in_ready  out  FIFO can accept (occupancy < DEPTH, not in reset)
//   in_data   in   WIDTH-bit entry
//   out_valid out  head entry valid
//   out_ready in   reader takes the head
//   out_data  out  head entry
// ----------------------------------------------------------------------------
module aes_fifo2 #(
    parameter int WIDTH = 132,
    parameter int DEPTH = 2     // only 2 is supported: 1-bit pointers, 2-bit count
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             push;
    logic             pop;

    // Reset is folded in so the upstream sees no ready while the stage is held.
    assign in_ready  = !reset && (count < 2'(DEPTH));
    assign out_valid = (count != 2'd0);
    assign out_data  = mem[rd_ptr];

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // NOTE: the storage is reset on purpose: the head must read as zero after
    // reset, and two entries cost little; a deep RAM would be left unreset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
        end else if (push) begin
            // NOTE: non-blocking assignments keep every register update in
            // this block reading pre-edge values, whatever the statement order.
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;   // 1 wraps to 0
            if (pop)  rd_ptr <= ~rd_ptr;
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;   // idle, or push and pop together
            endcase
        end
    end

endmodule

// File: rtl/shift_rows_stage.sv
// ----------------------------------------------------------------------------
// shift_rows_stage
// Forward AES ShiftRows stage with a 2-entry output FIFO. Each accepted state
// is shifted (or passed through when shift_en is low) and queued with its tag.
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   in_valid   in   upstream state present on data_in
//   in_ready   out  stage can accept this cycle
//   data_in    in   128-bit AES state, byte 0 at the MSB
//   shift_en   in   1 = ShiftRows, 0 = pass-through (sampled with data_in)
//   tag_in     in   round tag, travels with its block
//   out_valid  out  FIFO head valid
//   out_ready  in   downstream takes the head
//   data_out   out  head state
//   tag_out    out  head tag
//   blk_cnt    out  delivered blocks, modulo 256
// ----------------------------------------------------------------------------
module shift_rows_stage
    import aes_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int TAG_W = TAG_W_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] data_in,
    input  logic               shift_en,
    input  logic [TAG_W-1:0]   tag_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] data_out,
    output logic [TAG_W-1:0]   tag_out,
    output logic [7:0]         blk_cnt
);

    localparam int ENTRY_W = TAG_W + STATE_W;

    state_t             state_next;
    logic [ENTRY_W-1:0] fifo_in;
    logic [ENTRY_W-1:0] fifo_out;
    logic               deliver;

    // The permutation is wiring only, so it sits in front of the FIFO write.
    always_comb begin
        state_next = shift_en ? shift_rows(data_in) : data_in;
    end

    assign fifo_in = {tag_in, state_next};

    aes_fifo2 #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (fifo_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (fifo_out)
    );

    assign data_out = fifo_out[STATE_W-1:0];
    assign tag_out  = fifo_out[ENTRY_W-1 -: TAG_W];
    assign deliver  = out_valid && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blk_cnt <= 8'd0;
        end else if (deliver) begin
            blk_cnt <= blk_cnt + 8'd1;   // wraps 255 -> 0
        end
    end

endmodule

// File: tb/tb_shift_rows_stage.sv
// ----------------------------------------------------------------------------
// tb_shift_rows_stage
// Self-checking bench: directed table vectors, back-pressure, reset mid-stream,
// streaming and random stalls, all checked against a row/column ShiftRows
// model and an in-order scoreboard queue.
// ----------------------------------------------------------------------------
module tb_shift_rows_stage;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] data_in;
    logic         shift_en;
    logic [3:0]   tag_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] data_out;
    logic [3:0]   tag_out;
    logic [7:0]   blk_cnt;

    always #5 clk = ~clk;

    shift_rows_stage dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .shift_en  (shift_en),
        .tag_in    (tag_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .tag_out   (tag_out),
        .blk_cnt   (blk_cnt)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: state byte (row r, column c) lives at index r + 4c.
    // ShiftRows rotates row r left by r: out(r,c) = in(r, (c+r) mod 4).
    function automatic logic [127:0] ref_shift(input logic [127:0] s, input bit inverse);
        logic [127:0] r;
        int src_col;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                src_col = inverse ? (c - row + 4) % 4 : (c + row) % 4;
                r[127-8*(row+4*c) -: 8] = s[127-8*(row+4*src_col) -: 8];
            end
        end
        return r;
    endfunction

    typedef struct {
        logic [127:0] orig;
        logic         shift;
        logic [3:0]   tag;
    } entry_t;

    entry_t q[$];
    int     exp_blk   = 0;
    bit     sb_on     = 0;
    bit     delivered = 0;
    bit     accepted  = 0;

    // One clock: check outputs against the model at the falling edge, update
    // the model with this cycle's handshakes, then return just after the
    // next rising edge so the caller can drive new inputs.
    task automatic tick();
        entry_t e;
        @(negedge clk);
        delivered = 0;
        accepted  = 0;
        if (sb_on) begin
            check("out_valid", out_valid, q.size() != 0);
            check("in_ready", in_ready, q.size() < 2);
            check("blk_cnt", blk_cnt, exp_blk);
            if (q.size() != 0) begin
                e = q[0];
                check("data_out", data_out, e.shift ? ref_shift(e.orig, 0) : e.orig);
                check("tag_out", tag_out, e.tag);
                if (e.shift) check("round_trip", ref_shift(data_out, 1), e.orig);
            end
            accepted  = in_valid && (q.size() < 2);
            delivered = (q.size() != 0) && out_ready;
            if (delivered) begin
                void'(q.pop_front());
                exp_blk = (exp_blk + 1) % 256;
            end
            if (accepted) q.push_back('{data_in, shift_en, tag_in});
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [127:0] din;
        logic         sh;
        logic [3:0]   tag;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs[4];

    initial begin
        vecs[0] = '{128'h00112233445566778899aabbccddeeff, 1'b1, 4'd3,
                    128'h0055aaff4499ee3388dd2277cc1166bb};
        vecs[1] = '{128'h00112233445566778899aabbccddeeff, 1'b0, 4'd5,
                    128'h00112233445566778899aabbccddeeff};
        vecs[2] = '{128'h000102030405060708090a0b0c0d0e0f, 1'b1, 4'd15,
                    128'h00050a0f04090e03080d02070c01060b};
        vecs[3] = '{128'h0f0e0d0c0b0a09080706050403020100, 1'b1, 4'd9,
                    128'h0f0a05000b06010c07020d08030e0904};

        reset     = 1'b1;
        in_valid  = 1'b0;
        data_in   = '0;
        shift_en  = 1'b0;
        tag_in    = '0;
        out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_data_out", data_out, 128'h0);
        check("rst_tag_out", tag_out, 4'h0);
        check("rst_blk_cnt", blk_cnt, 8'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", in_ready, 1'b1);
        sb_on = 1;

        // Table vectors: one block each, visible the cycle after acceptance
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            data_in  = vecs[i].din;
            shift_en = vecs[i].sh;
            tag_in   = vecs[i].tag;
            tick();
            in_valid = 1'b0;
            check("vec_out_valid", out_valid, 1'b1);
            check("vec_data", data_out, vecs[i].exp);
            check("vec_tag", tag_out, vecs[i].tag);
            tick();
            check("vec_blk_cnt", blk_cnt, 8'(i + 1));
        end

        // Back-pressure: two accepted, third held off until space frees up
        out_ready = 1'b0;
        shift_en  = 1'b1;
        for (int b = 0; b < 2; b++) begin
            in_valid = 1'b1;
            data_in  = {$urandom, $urandom, $urandom, $urandom};
            tag_in   = 4'(8 + b);
            tick();
        end
        data_in = {$urandom, $urandom, $urandom, $urandom};
        tag_in  = 4'd10;
        check("bp_full_in_ready", in_ready, 1'b0);
        tick();
        check("bp_held_in_ready", in_ready, 1'b0);
        check("bp_head_tag", tag_out, 4'd8);
        out_ready = 1'b1;
        tick();
        check("bp_second_tag", tag_out, 4'd9);
        tick();
        in_valid = 1'b0;
        check("bp_third_tag", tag_out, 4'd10);
        tick();
        check("bp_drained", out_valid, 1'b0);
        check("bp_blk_cnt", blk_cnt, 8'd7);

        // Reset with two blocks buffered
        out_ready = 1'b0;
        for (int b = 0; b < 2; b++) begin
            in_valid = 1'b1;
            data_in  = {$urandom, $urandom, $urandom, $urandom};
            tag_in   = 4'(b + 1);
            tick();
        end
        in_valid = 1'b0;
        check("pre_rst_full", in_ready, 1'b0);
        reset = 1'b1;
        #1;
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_blk_cnt", blk_cnt, 8'd0);
        check("mid_rst_in_ready", in_ready, 1'b0);
        sb_on = 0;
        q.delete();
        exp_blk = 0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("after_rst_in_ready", in_ready, 1'b1);
        sb_on = 1;
        out_ready = 1'b1;
        repeat (3) tick();

        // Streaming: 300 back-to-back blocks
        in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            data_in  = {$urandom, $urandom, $urandom, $urandom};
            shift_en = 1'($urandom);
            tag_in   = 4'($urandom);
            tick();
            check("stream_accept", accepted, 1'b1);
            if (i > 0) check("stream_deliver", delivered, 1'b1);
        end
        in_valid = 1'b0;
        tick();
        check("stream_last_deliver", delivered, 1'b1);
        check("stream_blk_cnt", blk_cnt, 8'd44);

        // Random valid/ready stalls
        for (int i = 0; i < 10000; i++) begin
            in_valid  = 1'($urandom);
            out_ready = 1'($urandom);
            data_in   = {$urandom, $urandom, $urandom, $urandom};
            shift_en  = 1'($urandom);
            tag_in    = 4'($urandom);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("final_empty", out_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
